button_bank_decoder: RTL and testbench

- Parametrised successor to the four-button register selector.
- Synchronises an N-bit bank of raw push-button inputs and debounces the whole vector.
- Encodes a single debounced press into a binary index with a one-cycle valid pulse.
- Flags multi-button chords as errors and optionally auto-repeats a held button.
- Sits between the board pins and the operand/register-select logic of the matrix datapath.

---
 rtl/button_bank_decoder_if.sv | 34 +++
 rtl/button_bank_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_button_bank_decoder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/button_bank_decoder_if.sv
// Bus between the board's button pins and the register-select logic:
// raw button vector in, decoded press/chord/release events out.
interface button_bank_decoder_if #(
  parameter int N_BUTTONS = 4,
  parameter int IDX_W     = (N_BUTTONS > 2) ? $clog2(N_BUTTONS) : 1
);
  logic [N_BUTTONS-1:0] button_in;
  logic                 press_valid;
  logic [IDX_W-1:0]     press_idx;
  logic                 press_repeat;
  logic                 multi_err;
  logic                 held;
  logic                 released;

  modport master (
    input  button_in,
    output press_valid,
    output press_idx,
    output press_repeat,
    output multi_err,
    output held,
    output released
  );

  modport slave (
    output button_in,
    input  press_valid,
    input  press_idx,
    input  press_repeat,
    input  multi_err,
    input  held,
    input  released
  );
endinterface

// File: rtl/button_bank_decoder.sv
// Synchronises and debounces an N-bit push-button bank, encodes single presses
// into an index pulse, flags chords, and optionally auto-repeats a held button.
module button_bank_decoder #(
  parameter int N_BUTTONS       = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  button_bank_decoder_if.master bus
);
  localparam int IDX_W  = (N_BUTTONS > 2) ? $clog2(N_BUTTONS) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCNT_W = $clog2(RMAX + 1);

  localparam logic [CNT_W-1:0]  DEB_C   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [RCNT_W-1:0] DELAY_C = RCNT_W'(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] RATE_C  = RCNT_W'(REPEAT_RATE);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic [N_BUTTONS-1:0] sync_q [SYNC_STAGES];
  logic [N_BUTTONS-1:0] s;

  logic [1:0]           state_q, state_d;
  logic [N_BUTTONS-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [RCNT_W-1:0]    rcnt_q, rcnt_d, rcnt_inc, rthr;
  logic                 rphase_q, rphase_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic                 repeat_q, repeat_d;
  logic                 err_q, err_d;
  logic                 held_q, held_d;
  logic                 rel_q, rel_d;
  logic                 accept, release_ok, advance, fire_ok;

  function automatic logic is_onehot(input logic [N_BUTTONS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] encode(input logic [N_BUTTONS-1:0] v);
    logic [IDX_W-1:0] enc;
    enc = '0;
    for (int k = 0; k < N_BUTTONS; k++) begin
      if (v[k]) enc = IDX_W'(k);
    end
    return enc;
  endfunction

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.button_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign cnt_inc  = cnt_q + 1'b1;
  assign rcnt_inc = rcnt_q + 1'b1;
  assign rthr     = rphase_q ? RATE_C : DELAY_C;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    rcnt_d     = rcnt_q;
    rphase_d   = rphase_q;
    idx_d      = idx_q;
    valid_d    = 1'b0;
    repeat_d   = 1'b0;
    err_d      = 1'b0;
    rel_d      = 1'b0;
    accept     = 1'b0;
    release_ok = 1'b0;
    advance    = 1'b0;
    fire_ok    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s != '0) begin
          cand_d = s;
          cnt_d  = CNT_W'(1);
          if (DEBOUNCE_CYCLES == 1) accept = 1'b1;
          else state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (s == '0) begin
          state_d = ST_IDLE;
        end else if (s == cand_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB_C) accept = 1'b1;
        end else begin
          cand_d = s;
          cnt_d  = CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (s == '0) begin
          cnt_d = CNT_W'(1);
          if (DEBOUNCE_CYCLES == 1) release_ok = 1'b1;
          else state_d = ST_RELEASE;
        end else if (s == cand_q) begin
          advance = 1'b1;
          fire_ok = 1'b1;
        end
      end
      ST_RELEASE: begin
        // The repeat timer keeps running through a release bounce, but pulses are suppressed here.
        advance = 1'b1;
        if (s == '0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB_C) release_ok = 1'b1;
        end else begin
          state_d = ST_HELD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d  = ST_HELD;
      rcnt_d   = '0;
      rphase_d = 1'b0;
      if (is_onehot(s)) begin
        valid_d = 1'b1;
        idx_d   = encode(s);
      end else begin
        err_d = 1'b1;
      end
    end

    if (release_ok) begin
      rel_d   = 1'b1;
      state_d = ST_IDLE;
    end

    // After the first repeat the timer restarts from zero with the shorter rate period.
    if (advance) begin
      if (REPEAT_EN != 0) begin
        if (rcnt_inc == rthr) begin
          rcnt_d   = '0;
          rphase_d = 1'b1;
          valid_d  = fire_ok && is_onehot(cand_q);
          repeat_d = fire_ok && is_onehot(cand_q);
        end else begin
          rcnt_d = rcnt_inc;
        end
      end else if (rcnt_q != '1) begin
        rcnt_d = rcnt_inc;
      end
    end

    held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      rcnt_q   <= '0;
      rphase_q <= 1'b0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      repeat_q <= 1'b0;
      err_q    <= 1'b0;
      held_q   <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      rcnt_q   <= rcnt_d;
      rphase_q <= rphase_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      repeat_q <= repeat_d;
      err_q    <= err_d;
      held_q   <= held_d;
      rel_q    <= rel_d;
    end
  end

  assign bus.press_valid  = valid_q;
  assign bus.press_idx    = idx_q;
  assign bus.press_repeat = repeat_q;
  assign bus.multi_err    = err_q;
  assign bus.held         = held_q;
  assign bus.released     = rel_q;
endmodule

// File: tb/tb_button_bank_decoder.sv
// Three decoder configurations (defaults, 8-button slow debounce, auto-repeat)
// driven side by side and compared every cycle against a run-length reference model.
module tb_button_bank_decoder;
  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int checks = 0;
  int errors = 0;
  int segTick = 0;

  always #5 clk = ~clk;

  button_bank_decoder_if #(.N_BUTTONS(4)) ifA ();
  button_bank_decoder_if #(.N_BUTTONS(8)) ifB ();
  button_bank_decoder_if #(.N_BUTTONS(4)) ifC ();

  button_bank_decoder dutA (.clk(clk), .nrst(nrst), .bus(ifA));
  button_bank_decoder #(.N_BUTTONS(8), .DEBOUNCE_CYCLES(4)) dutB (.clk(clk), .nrst(nrst), .bus(ifB));
  button_bank_decoder #(.REPEAT_EN(1), .REPEAT_DELAY(16), .REPEAT_RATE(8)) dutC (.clk(clk), .nrst(nrst), .bus(ifC));

  // busy = a press was accepted and its release is not yet accepted; run/zrun are
  // lengths of the current run of identical (nonzero) or zero synchronised samples.
  typedef struct packed {
    logic [3:0][7:0] pipe;
    logic            busy;
    logic [7:0]      vec;
    logic [7:0]      prev;
    int              run;
    int              zrun;
    int              age;
    int              idx;
    logic            pv;
    logic            rep;
    logic            merr;
    logic            held;
    logic            rel;
  } model_t;

  model_t mA, mB, mC;
  int pvA[$], pvB[$], pvC[$], repC[$];
  int relA, relB, merrA, merrB;

  function automatic model_t modelStep(model_t m, logic [7:0] raw, logic rstn, int syncN,
                                       int deb, bit repEn, int dly, int rate);
    logic [7:0] s;
    int zb;
    m.pv = 1'b0; m.rep = 1'b0; m.merr = 1'b0; m.rel = 1'b0;
    if (!rstn) begin
      m = '0;
      return m;
    end
    s = m.pipe[syncN-1];
    for (int i = 3; i > 0; i--) m.pipe[i] = m.pipe[i-1];
    m.pipe[0] = raw;
    if (!m.busy) begin
      if (s == 8'd0) m.run = 0;
      else if (m.run > 0 && s == m.prev) m.run++;
      else m.run = 1;
      m.prev = s;
      if (m.run == deb) begin
        m.busy = 1'b1; m.vec = s; m.age = 0; m.zrun = 0; m.run = 0;
        if ($onehot(s)) begin m.pv = 1'b1; m.idx = $clog2(s); end
        else m.merr = 1'b1;
      end
    end else begin
      zb = m.zrun;
      if (s == 8'd0) m.zrun++; else m.zrun = 0;
      if (zb > 0 || s == m.vec) begin
        m.age++;
        if (repEn && zb == 0 && s == m.vec && $onehot(m.vec) &&
            (m.age == dly || (m.age > dly && (m.age - dly) % rate == 0))) begin
          m.pv = 1'b1; m.rep = 1'b1;
        end
      end
      if (m.zrun == deb) begin
        m.rel = 1'b1; m.busy = 1'b0; m.run = 0; m.zrun = 0;
      end
    end
    m.held = m.busy;
    return m;
  endfunction

  function automatic logic [7:0] randVec(int n);
    int kind;
    kind = $urandom_range(0, 3);
    if (kind == 0) return 8'd0;
    if (kind < 3) return 8'(8'd1 << $urandom_range(0, n - 1));
    return 8'($urandom) & ((n == 8) ? 8'hFF : 8'h0F);
  endfunction

  function automatic int qAt(int q[$], int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkDut(input string name, input model_t m, input logic pv, input logic [31:0] idx,
                          input logic rep, input logic merr, input logic hld, input logic rel);
    checkOutput({name, ".press_valid"}, 32'(pv), 32'(m.pv));
    checkOutput({name, ".press_idx"}, idx, m.idx);
    checkOutput({name, ".press_repeat"}, 32'(rep), 32'(m.rep));
    checkOutput({name, ".multi_err"}, 32'(merr), 32'(m.merr));
    checkOutput({name, ".held"}, 32'(hld), 32'(m.held));
    checkOutput({name, ".released"}, 32'(rel), 32'(m.rel));
  endtask

  task automatic clearEvents();
    segTick = 0;
    pvA.delete(); pvB.delete(); pvC.delete(); repC.delete();
    relA = 0; relB = 0; merrA = 0; merrB = 0;
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [7:0] b, input logic [3:0] c, input int n);
    ifA.button_in = a;
    ifB.button_in = b;
    ifC.button_in = c;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      mA = modelStep(mA, {4'b0, a}, nrst, 2, 1, 1'b0, 16, 8);
      mB = modelStep(mB, b, nrst, 2, 4, 1'b0, 16, 8);
      mC = modelStep(mC, {4'b0, c}, nrst, 2, 1, 1'b1, 16, 8);
      #1;
      segTick++;
      checkDut("A", mA, ifA.press_valid, 32'(ifA.press_idx), ifA.press_repeat, ifA.multi_err, ifA.held, ifA.released);
      checkDut("B", mB, ifB.press_valid, 32'(ifB.press_idx), ifB.press_repeat, ifB.multi_err, ifB.held, ifB.released);
      checkDut("C", mC, ifC.press_valid, 32'(ifC.press_idx), ifC.press_repeat, ifC.multi_err, ifC.held, ifC.released);
      if (ifA.press_valid) pvA.push_back(segTick);
      if (ifA.released) relA++;
      if (ifA.multi_err) merrA++;
      if (ifB.press_valid) pvB.push_back(segTick);
      if (ifB.released) relB++;
      if (ifB.multi_err) merrB++;
      if (ifC.press_valid) begin
        pvC.push_back(segTick);
        repC.push_back(int'(ifC.press_repeat));
      end
    end
  endtask

  initial begin
    int expC[6];
    int holdA, holdB, holdC;
    logic [7:0] tmp;
    logic [3:0] va, vc;
    logic [7:0] vb;
    expC = '{3, 19, 27, 35, 43, 51};
    mA = '0; mB = '0; mC = '0;
    ifA.button_in = '0; ifB.button_in = '0; ifC.button_in = '0;

    $display("[TB] reset");
    nrst = 1'b0;
    applyStimulus(4'h0, 8'h00, 4'h0, 2);
    checkOutput("reset.A.held", 32'(ifA.held), 0);
    checkOutput("reset.B.press_idx", 32'(ifB.press_idx), 0);
    checkOutput("reset.C.press_valid", 32'(ifC.press_valid), 0);
    nrst = 1'b1;
    applyStimulus(4'h0, 8'h00, 4'h0, 2);

    $display("[TB] single press, bounce, auto-repeat");
    clearEvents();
    applyStimulus(4'b0100, 8'h20, 4'b0010, 3);
    applyStimulus(4'b0100, 8'h00, 4'b0010, 1);
    applyStimulus(4'b0100, 8'h20, 4'b0010, 3);
    applyStimulus(4'b0100, 8'h00, 4'b0010, 1);
    applyStimulus(4'b0100, 8'h20, 4'b0010, 2);
    applyStimulus(4'b0000, 8'h20, 4'b0010, 10);
    applyStimulus(4'b0000, 8'h00, 4'b0010, 30);
    applyStimulus(4'b0000, 8'h00, 4'b0000, 10);
    checkOutput("A.press_count", pvA.size(), 1);
    checkOutput("A.press_tick", qAt(pvA, 0), 3);
    checkOutput("A.idx", 32'(ifA.press_idx), 2);
    checkOutput("A.release_count", relA, 1);
    checkOutput("A.err_count", merrA, 0);
    checkOutput("B.press_count", pvB.size(), 1);
    checkOutput("B.press_tick", qAt(pvB, 0), 14);
    checkOutput("B.idx", 32'(ifB.press_idx), 5);
    checkOutput("B.release_count", relB, 1);
    checkOutput("C.pulse_count", pvC.size(), 6);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("C.pulse%0d.tick", k), qAt(pvC, k), expC[k]);
      checkOutput($sformatf("C.pulse%0d.repeat", k), qAt(repC, k), (k == 0) ? 0 : 1);
    end
    checkOutput("C.idx", 32'(ifC.press_idx), 1);

    $display("[TB] chord error");
    clearEvents();
    applyStimulus(4'b0011, 8'h00, 4'h0, 8);
    applyStimulus(4'b0000, 8'h00, 4'h0, 6);
    checkOutput("multi.err_count", merrA, 1);
    checkOutput("multi.press_count", pvA.size(), 0);
    checkOutput("multi.idx_kept", 32'(ifA.press_idx), 2);

    $display("[TB] extra button while held");
    clearEvents();
    applyStimulus(4'b0001, 8'h00, 4'h0, 6);
    applyStimulus(4'b1001, 8'h00, 4'h0, 6);
    applyStimulus(4'b0000, 8'h00, 4'h0, 6);
    checkOutput("chord.first_idx", 32'(ifA.press_idx), 0);
    applyStimulus(4'b1000, 8'h00, 4'h0, 6);
    applyStimulus(4'b0000, 8'h00, 4'h0, 6);
    checkOutput("chord.press_count", pvA.size(), 2);
    checkOutput("chord.release_count", relA, 2);
    checkOutput("chord.last_idx", 32'(ifA.press_idx), 3);

    $display("[TB] reset mid-press");
    applyStimulus(4'b0010, 8'h04, 4'h0, 4);
    nrst = 1'b0;
    applyStimulus(4'b0010, 8'h04, 4'h0, 1);
    checkOutput("midreset.A.held", 32'(ifA.held), 0);
    checkOutput("midreset.A.press_idx", 32'(ifA.press_idx), 0);
    checkOutput("midreset.B.held", 32'(ifB.held), 0);
    nrst = 1'b1;
    clearEvents();
    applyStimulus(4'b0010, 8'h04, 4'h0, 8);
    applyStimulus(4'b0000, 8'h00, 4'h0, 8);
    checkOutput("midreset.A.press_count", pvA.size(), 1);
    checkOutput("midreset.A.press_tick", qAt(pvA, 0), 3);
    checkOutput("midreset.B.press_count", pvB.size(), 1);
    checkOutput("midreset.B.press_tick", qAt(pvB, 0), 6);
    checkOutput("midreset.B.idx", 32'(ifB.press_idx), 2);

    $display("[TB] random traffic");
    holdA = 0; holdB = 0; holdC = 0;
    va = '0; vb = '0; vc = '0;
    for (int t = 0; t < 500; t++) begin
      if (holdA == 0) begin tmp = randVec(4); va = tmp[3:0]; holdA = $urandom_range(1, 6); end
      if (holdB == 0) begin vb = randVec(8); holdB = $urandom_range(1, 8); end
      if (holdC == 0) begin tmp = randVec(4); vc = tmp[3:0]; holdC = $urandom_range(1, 40); end
      nrst = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      applyStimulus(va, vb, vc, 1);
      holdA--; holdB--; holdC--;
    end
    nrst = 1'b1;
    applyStimulus(4'h0, 8'h00, 4'h0, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
